// File: rtl/ula_pkg.sv
// Shared constants for the ula8bit ALU and its sequencer.
// ALU function codes, operation select and FSM state encoding.
package ula_pkg;

  localparam logic [1:0] F_AND  = 2'b00;
  localparam logic [1:0] F_OR   = 2'b01;
  localparam logic [1:0] F_NOTB = 2'b10;
  localparam logic [1:0] F_ADD  = 2'b11;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula8bit.sv
// 8-bit ripple ALU: AND / OR / NOT B / ADD with operand
// enables, A inversion and carry-in increment.
module ula8bit
  import ula_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_f0,
  input  logic       i_f1,
  input  logic       i_ena,
  input  logic       i_enb,
  input  logic       i_inva,
  input  logic       i_inc,
  output logic [7:0] o_out,
  output logic       o_cout
);

  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [8:0] w_sum;

  assign w_a   = (i_ena ? i_a : 8'h00) ^ {8{i_inva}};
  assign w_b   = i_enb ? i_b : 8'h00;
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {8'h00, i_inc};

  // function select; carry only meaningful for ADD
  always_comb begin
    o_out  = 8'h00;
    o_cout = 1'b0;
    case ({i_f0, i_f1})
      F_AND:  o_out = w_a & w_b;
      F_OR:   o_out = w_a | w_b;
      F_NOTB: o_out = ~w_b;
      F_ADD: begin
        o_out  = w_sum[7:0];
        o_cout = w_sum[8];
      end
      default: o_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/ula_seq8.sv
// Multi-cycle MUL (shift-add) / DIV (restoring) sequencer
// driving one ula8bit over 8 iterations.
module ula_seq8
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result
);

  state_t      r_state, w_state_nx;
  logic [2:0]  r_cnt, w_cnt_nx;
  logic        r_op, w_op_nx;
  logic [7:0]  r_acc, w_acc_nx;
  logic [7:0]  r_q, w_q_nx;
  logic [7:0]  r_m, w_m_nx;
  logic        r_err, w_err_nx;
  logic [15:0] r_res, w_res_nx;

  logic [1:0]  w_f;
  logic        w_ena, w_inva, w_inc;
  logic [7:0]  w_alu_b, w_rt;
  logic [7:0]  w_out;
  logic        w_cout, w_take;
  logic [7:0]  w_acc_it, w_q_it;

  assign w_rt   = {r_acc[6:0], r_q[7]};
  assign w_f    = F_ADD;
  assign w_take = r_acc[7] | w_cout;

  // ALU control decode for the current operation
  always_comb begin
    w_ena   = 1'b1;
    w_inva  = 1'b0;
    w_inc   = 1'b0;
    w_alu_b = r_acc;
    if (r_op == OP_MUL) begin
      w_ena = r_q[0];
    end else begin
      w_inva  = 1'b1;
      w_inc   = 1'b1;
      w_alu_b = w_rt;
    end
  end

  ula8bit u_alu (
    .i_a    (r_m),
    .i_b    (w_alu_b),
    .i_f0   (w_f[1]),
    .i_f1   (w_f[0]),
    .i_ena  (w_ena),
    .i_enb  (1'b1),
    .i_inva (w_inva),
    .i_inc  (w_inc),
    .o_out  (w_out),
    .o_cout (w_cout)
  );

  // one iteration's register update from the ALU result
  always_comb begin
    if (r_op == OP_MUL) begin
      w_acc_it = {w_cout, w_out[7:1]};
      w_q_it   = {w_out[0], r_q[7:1]};
    end else begin
      w_acc_it = w_take ? w_out : w_rt;
      w_q_it   = {r_q[6:0], w_take};
    end
  end

  // next-state and working-register decode
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_op_nx    = r_op;
    w_acc_nx   = r_acc;
    w_q_nx     = r_q;
    w_m_nx     = r_m;
    w_err_nx   = r_err;
    w_res_nx   = r_res;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_op_nx = op;
          if (op == OP_DIV && b == 8'h00) begin
            w_state_nx = S_DONE;
            w_err_nx   = 1'b1;
            w_res_nx   = {a, 8'hFF};
          end else begin
            w_state_nx = S_RUN;
            w_err_nx   = 1'b0;
            w_cnt_nx   = 3'd0;
            w_acc_nx   = 8'h00;
            w_q_nx     = (op == OP_MUL) ? b : a;
            w_m_nx     = (op == OP_MUL) ? a : b;
          end
        end else if (r_state == S_DONE) begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        w_acc_nx = w_acc_it;
        w_q_nx   = w_q_it;
        w_cnt_nx = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_res_nx   = {w_acc_it, w_q_it};
          w_state_nx = S_DONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_op    <= OP_MUL;
      r_acc   <= 8'h00;
      r_q     <= 8'h00;
      r_m     <= 8'h00;
      r_err   <= 1'b0;
      r_res   <= 16'h0000;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_op    <= w_op_nx;
      r_acc   <= w_acc_nx;
      r_q     <= w_q_nx;
      r_m     <= w_m_nx;
      r_err   <= w_err_nx;
      r_res   <= w_res_nx;
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign result = r_res;

endmodule

// File: tb/tb_ula_seq8.sv
// Scoreboard bench for ula_seq8: expected results queued at
// start, compared when done pulses.
module tb_ula_seq8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          bsy;
    int          c0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   bcnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  ula_seq8 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: count busy cycles, score each done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {16'h0, result}, {16'h0, e.res});
          check("err", {31'h0, err}, {31'h0, e.err});
          check("latency", cyc - e.c0, e.lat);
          check("busy_cycles", bcnt, e.bsy);
        end
        bcnt = 0;
      end
    end
  end

  // drive one request at a negedge; model the expected result
  task automatic issue(input logic o, input logic [7:0] x,
                       input logic [7:0] y);
    exp_t e;
    e.c0 = cyc;
    e.err = 1'b0;
    e.lat = 9;
    e.bsy = 8;
    if (o == 1'b0) begin
      e.res = 16'(x) * 16'(y);
    end else if (y == 8'h00) begin
      e.res = {x, 8'hFF};
      e.err = 1'b1;
      e.lat = 1;
      e.bsy = 0;
    end else begin
      e.res = {x % y, x / y};
    end
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_result", {16'h0, result}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 8'h0D, 8'h0B); wait_idle();
    issue(1'b0, 8'hFF, 8'hFF); wait_idle();
    issue(1'b0, 8'h00, 8'hFF); wait_idle();
    issue(1'b1, 8'd200, 8'd7); wait_idle();
    repeat (3) @(negedge clk);
    check("hold", {16'h0, result}, 32'h041C);
    issue(1'b1, 8'hFF, 8'h01); wait_idle();
    issue(1'b1, 8'h80, 8'hFF); wait_idle();
    issue(1'b1, 8'h55, 8'h00); wait_idle();

    // start during RUN must be ignored
    issue(1'b0, 8'h0D, 8'h0B);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'h11; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // back-to-back: next start in the done cycle
    issue(1'b0, 8'h21, 8'h07);
    begin
      int n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("b2b_wait", 32'd1, 32'd0);
    end
    issue(1'b1, 8'hC8, 8'h0A);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom_range(1, 0)), 8'($urandom),
            8'($urandom_range(255, 0)));
      wait_idle();
    end

    // reset mid-RUN discards the operation
    issue(1'b0, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_done", {31'h0, done}, 32'd0);
    check("mid_rst_err", {31'h0, err}, 32'd0);
    check("mid_rst_result", {16'h0, result}, 32'h0);
    sb.delete();
    bcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 8'h03, 8'h05); wait_idle();
    check("final_result", {16'h0, result}, 32'h000F);
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
